// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, data LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       ipClk,
    input  logic       ipnReset,
    input  logic [7:0] ipTxData,
    input  logic       ipTxSend,
    output logic       opTxBusy,
    output logic       opTx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic       parity_r;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } tx_state_t;
`endif

    tx_state_t      state_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic           stop_idx_r;
    logic           tx_r;
    logic           busy_r;
    logic           bit_tick_s;

    assign bit_tick_s = (bit_cnt_r == CNT_ZERO);
    assign opTx       = tx_r;
    assign opTxBusy   = busy_r;

    // Transmit FSM: bit timing, shifting and registered line/busy outputs.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            // Every non-idle state shares the same bit-period counter.
            if (state_r != IDLE) begin
                if (bit_tick_s) begin
                    bit_cnt_r <= CNT_RELOAD;
                end else begin
                    bit_cnt_r <= bit_cnt_r - CNT_ONE;
                end
            end else begin
                bit_cnt_r <= CNT_RELOAD;
            end

            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (ipTxSend) begin
                        state_r    <= START;
                        busy_r     <= 1'b1;
                        tx_r       <= 1'b0;
                        shift_r    <= ipTxData;
                        bit_idx_r  <= 3'd0;
                        stop_idx_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_r   <= even_parity(ipTxData);
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_tick_s) begin
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                        state_r <= DATA;
                    end else begin
                        tx_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (bit_tick_s) begin
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            tx_r      <= parity_r;
                            state_r   <= PARITY;
`else
                            tx_r      <= 1'b1;
                            state_r   <= STOP;
`endif
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        tx_r <= tx_r;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick_s) begin
                        tx_r    <= 1'b1;
                        state_r <= STOP;
                    end else begin
                        tx_r <= parity_r;
                    end
                end
`endif
                STOP: begin
                    tx_r <= 1'b1;
                    if (bit_tick_s) begin
                        if (stop_idx_r == LAST_STOP) begin
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                            stop_idx_r <= 1'b0;
                        end else begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                        end
                    end else begin
                        stop_idx_r <= stop_idx_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
